// File: rtl/bcd_scan_driver.sv
// Binary -> packed BCD (serial double-dabble) feeding a time-multiplexed digit scanner.
// Optional LEADING_ZERO_BLANK_EN: blanks leading zero digits (digit_sel=0, bcd_out=F).
module bcd_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  bin_valid,
  output logic                  bin_ready,
  output logic [3:0]            bcd_out,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  overflow
);
  localparam int CONV_DIGITS = (BIN_W + 2) / 3 + 1;
  localparam int ACC_W       = CONV_DIGITS * 4;
  localparam int DISP_W      = NUM_DIGITS * 4;
  localparam int EXT_W       = ACC_W + DISP_W;
  localparam int CNT_W       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BCNT_W      = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

  state_t              state_q;
  logic                ready_q;
  logic [BIN_W-1:0]    shift_q, shift_d;
  logic [ACC_W-1:0]    acc_q, acc_d, acc_adj;
  logic [BCNT_W-1:0]   bcnt_q;
  logic [DISP_W-1:0]   disp_q;
  logic                ovf_q;
  logic [EXT_W-1:0]    acc_ext;
  logic                hi_nz;

  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic [NUM_DIGITS-1:0] sel_q;
  logic [3:0]            bcd_q;

  // One double-dabble step: add 3 to every digit >= 5, then shift {acc, shift} left.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < CONV_DIGITS; i++) begin
      if (acc_q[i*4 +: 4] >= 4'd5) acc_adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
    end
    {acc_d, shift_d} = {acc_adj[ACC_W-2:0], shift_q, 1'b0};
  end

  // Zero-extend so the display slice exists even when the converter is narrower than the display.
  assign acc_ext = EXT_W'(acc_q);
  assign hi_nz   = |acc_ext[EXT_W-1:DISP_W];

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic                  zero_above;

  always_comb begin
    blank_d    = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (acc_ext[i*4 +: 4] == 4'd0);
      blank_d[i] = zero_above;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      shift_q <= '0;
      acc_q   <= '0;
      bcnt_q  <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blank_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bin_valid && ready_q) begin
            shift_q <= bin_in;
            acc_q   <= '0;
            bcnt_q  <= '0;
            ready_q <= 1'b0;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          acc_q   <= acc_d;
          shift_q <= shift_d;
          bcnt_q  <= bcnt_q + 1'b1;
          if (bcnt_q == BCNT_W'(BIN_W - 1)) state_q <= LOAD;
        end
        LOAD: begin
          if (hi_nz) begin
            disp_q  <= {NUM_DIGITS{4'h9}};
            ovf_q   <= 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
            blank_q <= '0;
`endif
          end else begin
            disp_q  <= acc_ext[DISP_W-1:0];
            ovf_q   <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            blank_q <= blank_d;
`endif
          end
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Free-running scan; outputs registered from the current index and display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      sel_q <= NUM_DIGITS'(1);
      bcd_q <= 4'd0;
    end else begin
      if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
        cnt_q <= '0;
        idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      sel_q <= NUM_DIGITS'(1) << idx_q;
      bcd_q <= disp_q[{idx_q, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      if (blank_q[idx_q]) begin
        sel_q <= '0;
        bcd_q <= 4'hF;
      end
`endif
    end
  end

  assign bin_ready = ready_q;
  assign bcd_out   = bcd_q;
  assign digit_sel = sel_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Scoreboard bench for bcd_scan_driver (NUM_DIGITS=4, BIN_W=14, SCAN_DIV=4).
module tb_bcd_scan_driver;
  localparam int ND = 4;
  localparam int BW = 14;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [BW-1:0] bin_in = '0;
  logic          bin_valid = 1'b0;
  logic          bin_ready;
  logic [3:0]    bcd_out;
  logic [ND-1:0] digit_sel;
  logic          overflow;

  bcd_scan_driver #(.NUM_DIGITS(ND), .BIN_W(BW), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .bin_valid(bin_valid),
    .bin_ready(bin_ready), .bcd_out(bcd_out), .digit_sel(digit_sel), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]   bcd;
    logic          ovf;
    logic [ND-1:0] blank;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   edges = 0;

  // Edges since the last reset release: the bench's own view of the scan position.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;

  function automatic exp_t mk(input int v);
    exp_t e;
    int   t;
    e.blank = '0;
    if (v > 9999) begin
      e.bcd = 16'h9999;
      e.ovf = 1'b1;
    end else begin
      t = v;
      for (int i = 0; i < 4; i++) begin
        e.bcd[i*4 +: 4] = 4'(t % 10);
        t = t / 10;
      end
      e.ovf = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      t = 10;
      for (int i = 1; i < ND; i++) begin
        e.blank[i] = (v < t);
        t = t * 10;
      end
`endif
    end
    return e;
  endfunction

  // Sends one value, returns the number of sampled cycles with bin_ready low.
  task automatic send(input int v, output int lowcnt);
    @(negedge clk);
    bin_in = BW'(v);
    bin_valid = 1'b1;
    sb.push_back(mk(v));
    @(negedge clk);
    bin_valid = 1'b0;
    lowcnt = 0;
    while (bin_ready === 1'b0 && lowcnt < 100) begin
      lowcnt++;
      @(negedge clk);
    end
  endtask

  // Pops one expectation and checks a full scan round (all slots) plus overflow.
  task automatic check_scan(input string name);
    exp_t       e;
    int         slot;
    logic [3:0] sel_e;
    logic [3:0] bcd_e;
    n_total++;
    if (sb.size() == 0) begin
      $display("FAIL %s scoreboard empty", name);
      return;
    end
    n_pass++;
    e = sb.pop_front();
    n_total++;
    if (overflow !== e.ovf) $display("FAIL %s overflow got %b want %b", name, overflow, e.ovf);
    else n_pass++;
    for (int n = 0; n < ND * SD + 2; n++) begin
      slot  = (edges == 0) ? 0 : ((edges - 1) / SD) % ND;
      sel_e = 4'b0001 << slot;
      bcd_e = e.bcd[slot*4 +: 4];
      if (e.blank[slot]) begin
        sel_e = 4'b0000;
        bcd_e = 4'hF;
      end
      n_total++;
      if (digit_sel !== sel_e)
        $display("FAIL %s digit_sel slot %0d got %b want %b", name, slot, digit_sel, sel_e);
      else n_pass++;
      n_total++;
      if (bcd_out !== bcd_e)
        $display("FAIL %s bcd_out slot %0d got %h want %h", name, slot, bcd_out, bcd_e);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic check_latency(input string name, input int lowcnt);
    n_total++;
    if (lowcnt !== BW + 1) $display("FAIL %s bin_ready low cycles got %0d want %0d", name, lowcnt, BW + 1);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    n_total += 4;
    if (bin_ready !== 1'b1) $display("FAIL reset bin_ready got %b want 1", bin_ready); else n_pass++;
    if (bcd_out !== 4'h0) $display("FAIL reset bcd_out got %h want 0", bcd_out); else n_pass++;
    if (digit_sel !== 4'b0001) $display("FAIL reset digit_sel got %b want 0001", digit_sel); else n_pass++;
    if (overflow !== 1'b0) $display("FAIL reset overflow got %b want 0", overflow); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(mk(0));
    check_scan("idle_scan");
    n_total++;
    if (bin_ready !== 1'b1) $display("FAIL idle bin_ready got %b want 1", bin_ready); else n_pass++;
  endtask

  task automatic test_convert();
    int lc;
    send(1234, lc);
    check_latency("conv1234", lc);
    check_scan("conv1234");
  endtask

  task automatic test_overflow();
    int lc;
    send(12000, lc);
    check_latency("ovf12000", lc);
    check_scan("ovf12000");
    send(9999, lc);
    check_latency("max9999", lc);
    check_scan("max9999");
  endtask

  task automatic test_ignore_busy();
    int lc;
    @(negedge clk);
    bin_in = BW'(1234);
    bin_valid = 1'b1;
    sb.push_back(mk(1234));
    @(negedge clk);
    bin_in = BW'(5678);
    repeat (5) @(negedge clk);
    bin_valid = 1'b0;
    lc = 5;
    while (bin_ready === 1'b0 && lc < 100) begin
      lc++;
      @(negedge clk);
    end
    check_latency("busy_ignore", lc);
    check_scan("busy_ignore");
  endtask

  task automatic test_reset_mid_convert();
    int lc;
    @(negedge clk);
    bin_in = BW'(4321);
    bin_valid = 1'b1;
    @(negedge clk);
    bin_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total += 4;
    if (bin_ready !== 1'b1) $display("FAIL midrst bin_ready got %b want 1", bin_ready); else n_pass++;
    if (bcd_out !== 4'h0) $display("FAIL midrst bcd_out got %h want 0", bcd_out); else n_pass++;
    if (digit_sel !== 4'b0001) $display("FAIL midrst digit_sel got %b want 0001", digit_sel); else n_pass++;
    if (overflow !== 1'b0) $display("FAIL midrst overflow got %b want 0", overflow); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(mk(0));
    check_scan("midrst_scan");
    n_total++;
    if (bin_ready !== 1'b1) $display("FAIL midrst ready after release got %b want 1", bin_ready); else n_pass++;
    send(4321, lc);
    check_latency("after_rst", lc);
    check_scan("after_rst");
  endtask

`ifdef LEADING_ZERO_BLANK_EN
  task automatic test_blank();
    int lc;
    send(42, lc);
    check_latency("blank42", lc);
    check_scan("blank42");
    send(0, lc);
    check_latency("blank0", lc);
    check_scan("blank0");
    send(12000, lc);
    check_latency("blank_ovf", lc);
    check_scan("blank_ovf");
  endtask
`endif

  initial begin
    test_reset();
    test_convert();
    test_overflow();
    test_ignore_busy();
    test_reset_mid_convert();
`ifdef LEADING_ZERO_BLANK_EN
    test_blank();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

endmodule
